// File: rtl/wts_pkg.sv
// Shared defaults and helpers for the wave table channel volume pipeline.
package wts_pkg;

    localparam int DEF_NCH    = 5;
    localparam int DEF_CH_W   = 3;
    localparam int DEF_WAVE_W = 8;
    localparam int DEF_ENV_W  = 8;
    localparam int DEF_VOL_W  = 4;
    localparam int DEF_MIX_W  = 11;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned        width);
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        maxv = (64'sd1 <<< (width - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (width - 1));
        if (value > maxv) begin
            return maxv;
        end else if (value < minv) begin
            return minv;
        end
        return value;
    endfunction

endpackage

// File: rtl/wts_scale_round.sv
// Signed x unsigned scale by k/2**K_W, result rounded toward zero.
// |k/2**K_W| < 1 so the result always fits back into IN_W bits.
module wts_scale_round #(
    parameter int IN_W = 8,
    parameter int K_W  = 8
) (
    input  logic signed [IN_W-1:0] a_i,
    input  logic        [K_W-1:0]  k_i,
    output logic signed [IN_W-1:0] y_o
);

    localparam int P_W = IN_W + K_W + 1;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;
    logic                  rnd;

    // Multiply, floor-shift, then nudge negative inexact results up by one.
    always_comb begin
        prod    = P_W'(a_i) * P_W'($signed({1'b0, k_i}));
        shifted = prod >>> K_W;
        rnd     = prod[P_W-1] & (|prod[K_W-1:0]);
        y_o     = IN_W'(shifted + {{(P_W-1){1'b0}}, rnd});
    end

endmodule

// File: rtl/wts_channel_volume_mux.sv
// Time-multiplexed channel volume stage: envelope scale, volume scale with
// mute, per-channel output and a saturated per-frame mix.
module wts_channel_volume_mux
    import wts_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int CH_W   = DEF_CH_W,
    parameter int WAVE_W = DEF_WAVE_W,
    parameter int ENV_W  = DEF_ENV_W,
    parameter int VOL_W  = DEF_VOL_W,
    parameter int MIX_W  = DEF_MIX_W
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [WAVE_W-1:0] in_wave,
    input  logic [ENV_W:0]    in_envelope,
    input  logic [VOL_W-1:0]  in_volume,
    input  logic              in_mute,
    input  logic              in_last,
    output logic              ch_valid,
    output logic [CH_W-1:0]   ch_index,
    output logic [WAVE_W-1:0] ch_out,
    output logic              mix_valid,
    output logic [MIX_W-1:0]  mix_out
);

    localparam int ACC_W  = WAVE_W + clog2(NCH) + 1;
    localparam int STAGES = 3;

    // valid travels alongside the data; bit i is stage i+1
    logic [STAGES-1:0] vld_pipe_q;

    // S1: captured slot
    logic signed [WAVE_W-1:0] s1_wave_q;
    logic        [ENV_W:0]    s1_env_q;
    logic        [VOL_W-1:0]  s1_vol_q;
    logic                     s1_mute_q;
    logic                     s1_last_q;
    logic        [CH_W-1:0]   s1_ch_q;

    // S2: envelope-scaled sample
    logic signed [WAVE_W-1:0] s2_e_q;
    logic        [VOL_W-1:0]  s2_vol_q;
    logic                     s2_mute_q;
    logic                     s2_last_q;
    logic        [CH_W-1:0]   s2_ch_q;

    // S3: outputs and frame accumulator
    logic signed [WAVE_W-1:0] ch_out_q;
    logic        [CH_W-1:0]   ch_index_q;
    logic                     mix_valid_q;
    logic signed [MIX_W-1:0]  mix_out_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic signed [WAVE_W-1:0] env_scaled;
    logic signed [WAVE_W-1:0] vol_scaled;
    logic signed [WAVE_W-1:0] e_d;
    logic signed [WAVE_W-1:0] v_d;
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [MIX_W-1:0]  mix_sat_d;

    wts_scale_round #(.IN_W(WAVE_W), .K_W(ENV_W)) u_env_scale (
        .a_i (s1_wave_q),
        .k_i (s1_env_q[ENV_W-1:0]),
        .y_o (env_scaled)
    );

    wts_scale_round #(.IN_W(WAVE_W), .K_W(VOL_W)) u_vol_scale (
        .a_i (s2_e_q),
        .k_i (s2_vol_q),
        .y_o (vol_scaled)
    );

    // Bypass, mute, and the running sum that the S3 slot would produce.
    always_comb begin
        e_d       = s1_env_q[ENV_W] ? s1_wave_q : env_scaled;
        v_d       = s2_mute_q ? '0 : vol_scaled;
        sum_d     = acc_q + {{(ACC_W-WAVE_W){v_d[WAVE_W-1]}}, v_d};
        mix_sat_d = MIX_W'(sat_signed({{(64-ACC_W){sum_d[ACC_W-1]}}, sum_d}, MIX_W));
    end

    // Valid shift register; no backpressure, so it always advances.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], in_valid};
        end
    end

    // S1 capture of the incoming slot.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_wave_q <= '0;
            s1_env_q  <= '0;
            s1_vol_q  <= '0;
            s1_mute_q <= 1'b0;
            s1_last_q <= 1'b0;
            s1_ch_q   <= '0;
        end else begin
            s1_wave_q <= in_wave;
            s1_env_q  <= in_envelope;
            s1_vol_q  <= in_volume;
            s1_mute_q <= in_mute;
            s1_last_q <= in_last;
            s1_ch_q   <= in_ch;
        end
    end

    // S2 envelope step result plus sidebands.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s2_e_q    <= '0;
            s2_vol_q  <= '0;
            s2_mute_q <= 1'b0;
            s2_last_q <= 1'b0;
            s2_ch_q   <= '0;
        end else begin
            s2_e_q    <= e_d;
            s2_vol_q  <= s1_vol_q;
            s2_mute_q <= s1_mute_q;
            s2_last_q <= s1_last_q;
            s2_ch_q   <= s1_ch_q;
        end
    end

    // S3 outputs and mix; the last slot publishes the sum and restarts at 0
    // so a following frame's first slot accumulates from a clean base.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ch_out_q    <= '0;
            ch_index_q  <= '0;
            mix_valid_q <= 1'b0;
            mix_out_q   <= '0;
            acc_q       <= '0;
        end else begin
            mix_valid_q <= 1'b0;
            if (vld_pipe_q[1]) begin
                ch_out_q   <= v_d;
                ch_index_q <= s2_ch_q;
                if (s2_last_q) begin
                    mix_out_q   <= mix_sat_d;
                    mix_valid_q <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    assign ch_valid  = vld_pipe_q[STAGES-1];
    assign ch_index  = ch_index_q;
    assign ch_out    = ch_out_q;
    assign mix_valid = mix_valid_q;
    assign mix_out   = mix_out_q;

endmodule

// File: tb/tb_wts_channel_volume_mux.sv
// Directed bench for wts_channel_volume_mux; a second instance with a
// narrow mix exercises saturation on the same stimulus.
module tb_wts_channel_volume_mux;

    logic       clk = 1'b0;
    logic       nreset;
    logic       in_valid;
    logic [2:0] in_ch;
    logic [7:0] in_wave;
    logic [8:0] in_envelope;
    logic [3:0] in_volume;
    logic       in_mute;
    logic       in_last;

    logic        ch_valid, mix_valid;
    logic [2:0]  ch_index;
    logic [7:0]  ch_out;
    logic [10:0] mix_out;

    logic        ch_valid_s, mix_valid_s;
    logic [2:0]  ch_index_s;
    logic [7:0]  ch_out_s;
    logic [8:0]  mix_out_s;

    int checks = 0;
    int errors = 0;
    int ch_ctr = 0;
    int mix_ch_bad = 0;
    int chq[$];
    int mixq[$];
    int mix9q[$];

    wts_channel_volume_mux dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ch(in_ch),
        .in_wave(in_wave), .in_envelope(in_envelope), .in_volume(in_volume),
        .in_mute(in_mute), .in_last(in_last), .ch_valid(ch_valid),
        .ch_index(ch_index), .ch_out(ch_out), .mix_valid(mix_valid),
        .mix_out(mix_out)
    );

    wts_channel_volume_mux #(.MIX_W(9)) dut_sat (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ch(in_ch),
        .in_wave(in_wave), .in_envelope(in_envelope), .in_volume(in_volume),
        .in_mute(in_mute), .in_last(in_last), .ch_valid(ch_valid_s),
        .ch_index(ch_index_s), .ch_out(ch_out_s), .mix_valid(mix_valid_s),
        .mix_out(mix_out_s)
    );

    always #5 clk = ~clk;

    // output collector, sampled away from the active edge
    always @(negedge clk) begin
        if (ch_valid) chq.push_back(int'($signed(ch_out)));
        if (mix_valid) begin
            mixq.push_back(int'($signed(mix_out)));
            if (!ch_valid) mix_ch_bad = mix_ch_bad + 1;
        end
        if (mix_valid_s) mix9q.push_back(int'($signed(mix_out_s)));
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic slot(input int wave, input int env, input int vol,
                        input bit mute, input bit last);
        @(negedge clk);
        in_valid    = 1'b1;
        in_wave     = 8'(wave);
        in_envelope = 9'(env);
        in_volume   = 4'(vol);
        in_mute     = mute;
        in_last     = last;
        in_ch       = 3'(ch_ctr);
        ch_ctr      = (ch_ctr + 1) % 5;
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_mute  = 1'b0;
    endtask

    task automatic drain();
        bubble();
        repeat (6) @(negedge clk);
        chq.delete();
        mixq.delete();
        mix9q.delete();
        mix_ch_bad = 0;
    endtask

    task automatic flush_and_keep();
        bubble();
        repeat (6) @(negedge clk);
    endtask

    task automatic run_one(input string tag, input int wave, input int env,
                           input int vol, input bit mute, input int exp);
        slot(wave, env, vol, mute, 1'b1);
        flush_and_keep();
        chk({tag, "_cnt"}, chq.size(), 1);
        chk(tag, (chq.size() > 0) ? chq[0] : 9999, exp);
        drain();
    endtask

    task automatic frame(input int wave, input bit gaps);
        for (int i = 0; i < 5; i++) begin
            slot(wave, 'h100, 15, 1'b0, i == 4);
            if (gaps && i < 4) bubble();
        end
    endtask

    initial begin
        nreset = 1'b0;
        in_valid = 0; in_ch = 0; in_wave = 0; in_envelope = 0;
        in_volume = 0; in_mute = 0; in_last = 0;

        // 1: reset with random inputs, then latency of one slot
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'($urandom); in_ch = 3'($urandom); in_wave = 8'($urandom);
            in_envelope = 9'($urandom); in_volume = 4'($urandom);
            in_mute = 1'($urandom); in_last = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_ch_index", ch_index, 0);
        chk("rst_ch_out", ch_out, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_mix_out", mix_out, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        nreset   = 1'b1;
        repeat (2) @(negedge clk);
        drain();

        ch_ctr = 3;
        slot('h40, 'h100, 15, 1'b0, 1'b1);
        bubble();
        chk("lat_c1", ch_valid, 0);
        @(negedge clk);
        chk("lat_c2", ch_valid, 0);
        @(negedge clk);
        chk("lat_c3", ch_valid, 1);
        chk("lat_out", $signed(ch_out), 60);
        chk("lat_idx", ch_index, 3);
        drain();

        // 2: rounding toward zero
        run_one("rnd_m1", -1, 'h001, 15, 1'b0, 0);
        run_one("rnd_m128", -128, 'h080, 15, 1'b0, -60);
        run_one("rnd_127", 127, 'h0FF, 15, 1'b0, 118);

        // 3: bypass, mute, zero envelope, zero volume
        run_one("byp", 127, 'h100, 15, 1'b0, 119);
        run_one("mute", 127, 'h100, 15, 1'b1, 0);
        run_one("env0", 127, 'h000, 15, 1'b0, 0);
        run_one("vol0", 127, 'h100, 0, 1'b0, 0);

        // 4: two back-to-back frames
        frame(-128, 1'b0);
        frame(-128, 1'b0);
        flush_and_keep();
        chk("b2b_ch_cnt", chq.size(), 10);
        chk("b2b_ch9", (chq.size() > 9) ? chq[9] : 9999, -120);
        chk("b2b_mix_cnt", mixq.size(), 2);
        chk("b2b_mix0", (mixq.size() > 0) ? mixq[0] : 9999, -600);
        chk("b2b_mix1", (mixq.size() > 1) ? mixq[1] : 9999, -600);
        chk("b2b_mix_with_ch", mix_ch_bad, 0);
        drain();

        // 5: saturation on the narrow mix
        frame(127, 1'b0);
        flush_and_keep();
        chk("sat_pos9", (mix9q.size() > 0) ? mix9q[0] : 9999, 255);
        chk("sat_pos11", (mixq.size() > 0) ? mixq[0] : 9999, 595);
        drain();
        frame(-128, 1'b0);
        flush_and_keep();
        chk("sat_neg9", (mix9q.size() > 0) ? mix9q[0] : 9999, -256);
        drain();

        // 6: bubbles inside a frame, then a reset mid-frame
        frame(-128, 1'b1);
        flush_and_keep();
        chk("gap_mix_cnt", mixq.size(), 1);
        chk("gap_mix", (mixq.size() > 0) ? mixq[0] : 9999, -600);
        drain();

        slot(127, 'h100, 15, 1'b0, 1'b0);
        slot(127, 'h100, 15, 1'b0, 1'b0);
        @(negedge clk);
        nreset   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_ch_valid", ch_valid, 0);
        chk("mrst_mix_out", mix_out, 0);
        nreset = 1'b1;
        frame(-128, 1'b0);
        flush_and_keep();
        chk("mrst_ch_cnt", chq.size(), 5);
        chk("mrst_mix_cnt", mixq.size(), 1);
        chk("mrst_mix", (mixq.size() > 0) ? mixq[0] : 9999, -600);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wts_channel_volume_mux.md
Name: wts_channel_volume_mux

Overview:
- Time-multiplexed successor to the per-channel volume stage of the wave table sound core.
- One shared pipeline scales signed wave samples for NCH channels, in two steps:
  - by a per-channel envelope, with a full-scale bypass;
  - then by a per-channel register volume, with per-channel mute.
- Emits each scaled channel sample.
- Accumulates a saturated mix over one frame and emits it on the frame's last slot.
- Sits between the wave SRAM read sequencer and the DAC/output filter.

Parameters:
- NCH, 5, number of channels time-multiplexed per frame (>=1).
- CH_W, 3, channel index width; must satisfy 2**CH_W >= NCH.
- WAVE_W, 8, signed wave sample width; also the per-channel output width.
- ENV_W, 8, envelope magnitude width. The envelope port carries one extra MSB used as the bypass flag.
- VOL_W, 4, unsigned volume width; scale factor is volume/2**VOL_W.
- MIX_W, 11, signed mix output width; must be >= WAVE_W.

Ports:
- clk  in  1  rising-edge clock.
- nreset  in  1  asynchronous, active-low reset.
- in_valid  in  1  slot carries a sample this cycle.
- in_ch  in  CH_W  channel index of the slot; passed through only.
- in_wave  in  WAVE_W  signed wave sample.
- in_envelope  in  ENV_W+1  bit ENV_W = bypass (full scale); bits ENV_W-1:0 = unsigned envelope.
- in_volume  in  VOL_W  unsigned channel volume.
- in_mute  in  1  forces this slot's channel output to 0.
- in_last  in  1  marks the final slot of a frame; qualified by in_valid.
- ch_valid  out  1  scaled channel sample valid.
- ch_index  out  CH_W  channel index of ch_out.
- ch_out  out  WAVE_W  signed scaled channel sample.
- mix_valid  out  1  one-cycle pulse, mix_out updated.
- mix_out  out  MIX_W  signed saturated frame mix; held between pulses.

Behaviour:

Clock and reset:
- One clock domain. Reset is asynchronous and active-low on nreset.
- All flops, including valid bits and the accumulator, clear to 0 while nreset is low.
- Reset values: ch_valid=0, ch_index=0, ch_out=0, mix_valid=0, mix_out=0.

Handshake and latency:
- No backpressure; every in_valid slot is accepted.
- Bubbles (in_valid=0) are allowed anywhere and do not disturb the accumulator.

Pipeline (3 register stages; in_valid at cycle N gives ch_valid at N+3):
- S1: register wave, envelope, volume, mute, ch, last and valid.
- S2, envelope step:
  - p = signed(wave) * unsigned(env[ENV_W-1:0]), width WAVE_W+ENV_W+1.
  - e = p >>> ENV_W, rounded toward zero: if p<0 and p[ENV_W-1:0]!=0, add 1.
  - If env[ENV_W]=1 then e = wave unchanged.
  - Result width WAVE_W; cannot overflow.
- S3, volume step:
  - q = signed(e) * unsigned(volume); v = q >>> VOL_W, rounded toward zero the same way.
  - If mute=1 then v = 0.
  - Register as ch_out with ch_valid, ch_index.
- Valid and sideband bits travel with the data through every stage.

Mix accumulator:
- Signed accumulator, width WAVE_W + clog2(NCH) + 1.
- On a valid S3 result: sum = acc + v (sign-extended).
  - last=0: acc <= sum.
  - last=1: mix_out <= sat(sum) clamped to [-2**(MIX_W-1), 2**(MIX_W-1)-1], mix_valid <= 1 for one cycle, and acc <= 0.
- mix_valid and mix_out are registered together with ch_valid, so a last slot gives ch_valid and mix_valid on the same cycle.
- Back-to-back frames: a new frame's first slot may follow the previous last slot directly. The cleared accumulator is the base for that slot; no slot is lost.
- A frame with more or fewer than NCH slots is legal; the mix covers all valid slots up to in_last.
- Muted slots still count as frame slots and contribute 0; in_last on a muted slot still closes the frame.

Reset and boundaries:
- Reset mid-frame discards the partial accumulation and all in-flight slots; no mix_valid is produced for that frame.
- Boundary values:
  - volume 0 gives 0.
  - Full-scale volume is (2**VOL_W-1)/2**VOL_W; there is no unity gain on the volume step.
  - Envelope 0 without bypass gives 0.

Decomposition:
- Package wts_pkg holds:
  - default widths NCH, CH_W, WAVE_W, ENV_W, VOL_W, MIX_W;
  - function clog2;
  - function sat_signed(value, width).
- One sub-module, wts_scale_round (params IN_W, K_W):
  - signed IN_W × unsigned K_W multiply, arithmetic shift by K_W, round toward zero;
  - purely combinational;
  - instantiated once in S2 and once in S3.
- The pipeline and accumulator stay in the top module.

Test Plan:
1. Reset: hold nreset low with random inputs -> all outputs 0. Release, one slot wave=0x40, env=0x100, vol=0xF -> ch_valid exactly 3 cycles later, ch_out=0x3C (64*15/16=60).
2. Rounding toward zero:
   - wave=-1 (0xFF), env=0x001, vol=0xF -> ch_out=0x00.
   - wave=-128, env=0x080, vol=0xF -> e=-64, ch_out=-60 (0xC4).
   - wave=127, env=0x0FF, vol=0xF -> e=126, ch_out=118.
3. Bypass, mute, zero:
   - wave=127, env=0x100, vol=0xF -> 119.
   - Same with in_mute=1 -> 0.
   - env=0x000 -> 0.
   - vol=0 -> 0.
4. Mix and back-to-back frames: two frames of 5 slots each, wave=-128, env bypass, vol=0xF, in_last on slots 4 and 9, no bubbles:
   - each frame -> mix_out=-600 on that frame's slot-4 ch_valid cycle;
   - second frame not contaminated by the first.
5. Saturation with MIX_W=9:
   - 5 slots of wave=127, env bypass, vol=0xF -> mix_out=255 (true sum 595);
   - wave=-128 -> mix_out=-256.
6. Bubbles and mid-frame reset:
   - insert in_valid=0 gaps inside a frame -> same mix as the gapless run;
   - assert nreset after slot 2, then run a full 5-slot frame -> mix excludes pre-reset slots, and no mix_valid pulse occurs for the aborted frame.
